// File: rtl/bip_pkg.sv
// Shared definitions for the handshaked BIP accumulator core: opcode map,
// FSM state encoding, status flag bit positions and ALU operation select.
package bip_pkg;

    localparam int OP_W = 5;
    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_HLT  = 5'h00;
    localparam opcode_t OP_STO  = 5'h01;
    localparam opcode_t OP_LD   = 5'h02;
    localparam opcode_t OP_LDI  = 5'h03;
    localparam opcode_t OP_ADD  = 5'h04;
    localparam opcode_t OP_ADDI = 5'h05;
    localparam opcode_t OP_SUB  = 5'h06;
    localparam opcode_t OP_SUBI = 5'h07;
    localparam opcode_t OP_AND  = 5'h08;
    localparam opcode_t OP_ANDI = 5'h09;
    localparam opcode_t OP_OR   = 5'h0A;
    localparam opcode_t OP_ORI  = 5'h0B;
    localparam opcode_t OP_XOR  = 5'h0C;
    localparam opcode_t OP_XORI = 5'h0D;
    localparam opcode_t OP_SLL  = 5'h0E;
    localparam opcode_t OP_SRL  = 5'h0F;
    localparam opcode_t OP_SRA  = 5'h10;
    localparam opcode_t OP_BEQ  = 5'h11;
    localparam opcode_t OP_BNE  = 5'h12;
    localparam opcode_t OP_BLT  = 5'h13;
    localparam opcode_t OP_JMP  = 5'h14;
    // Any unassigned code behaves as a NOP; this one is the canonical encoding.
    localparam opcode_t OP_NOP  = 5'h1F;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // Bit positions inside the {Z,N,C} flag vector.
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_PASS
    } alu_op_t;

    // Map an instruction opcode onto the ALU operation it needs.
    function automatic alu_op_t alu_sel(input opcode_t op);
        case (op)
            OP_ADD, OP_ADDI: return ALU_ADD;
            OP_SUB, OP_SUBI: return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR,  OP_ORI:  return ALU_OR;
            OP_XOR, OP_XORI: return ALU_XOR;
            OP_SLL:          return ALU_SLL;
            OP_SRL:          return ALU_SRL;
            OP_SRA:          return ALU_SRA;
            default:         return ALU_PASS;
        endcase
    endfunction

    // Instructions that need a data memory transaction.
    function automatic logic is_mem_op(input opcode_t op);
        case (op)
            OP_STO, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ALU instructions that finish in S_EXEC using the immediate operand.
    function automatic logic is_alu_imm_op(input opcode_t op);
        case (op)
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI,
            OP_SLL, OP_SRL, OP_SRA: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bip_alu.sv
// Combinational ALU: arithmetic with carry/borrow, logical ops, and shifts
// that report the last bit shifted out on carry.
module bip_alu
    import bip_pkg::*;
#(
    parameter int NBITS_D = 16
) (
    input  alu_op_t              op,
    input  logic [NBITS_D-1:0]   a,
    input  logic [NBITS_D-1:0]   b,
    output logic [NBITS_D-1:0]   result,
    output logic                 carry
);

    localparam int SH_W = $clog2(NBITS_D);

    logic [SH_W-1:0]  shamt;
    logic [NBITS_D:0] wide;

    assign shamt = b[SH_W-1:0];

    // Result and carry for the selected operation; logical ops clear carry.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        result = a;
        carry  = 1'b0;
        wide   = '0;
        case (op)
            ALU_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[NBITS_D-1:0];
                carry  = wide[NBITS_D];
            end
            ALU_SUB: begin
                // The extra MSB goes high exactly when a < b, i.e. on borrow.
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[NBITS_D-1:0];
                carry  = wide[NBITS_D];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: begin
                wide   = {1'b0, a} << shamt;
                result = wide[NBITS_D-1:0];
                carry  = wide[NBITS_D];
            end
            ALU_SRL: begin
                wide   = {a, 1'b0} >> shamt;
                result = wide[NBITS_D:1];
                carry  = wide[0];
            end
            ALU_SRA: begin
                wide   = $unsigned($signed({a, 1'b0}) >>> shamt);
                result = wide[NBITS_D:1];
                carry  = wide[0];
            end
            ALU_PASS: result = b;
            default: ;
        endcase
    end

endmodule

// File: rtl/bip_cpu_hs.sv
// BIP accumulator CPU with fetch/exec/mem FSM and level req/ack handshakes
// toward program and data memory. PC, IR, ACC and flags live here.
module bip_cpu_hs
    import bip_pkg::*;
#(
    parameter int                 NBITS_O  = 11,
    parameter int                 NBITS_D  = 16,
    parameter int                 OPCODE   = 5,
    parameter logic [NBITS_O-1:0] RESET_PC = '0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NBITS_D-1:0]   i_Instruction,
    input  logic                 i_PmAck,
    input  logic [NBITS_D-1:0]   i_OutData,
    input  logic                 i_DmAck,
    output logic [NBITS_O-1:0]   o_PmAddr,
    output logic                 o_PmReq,
    output logic [NBITS_O-1:0]   o_DmAddr,
    output logic                 o_Rd,
    output logic                 o_Wr,
    output logic [NBITS_D-1:0]   o_InData,
    output logic [2:0]           o_Flags,
    output logic                 o_Halt
);

    // Operand field width; NBITS_O must not exceed it.
    localparam int NBITS_OPND = NBITS_D - OPCODE;

    state_t                 state, state_next;
    logic [NBITS_O-1:0]     pc, pc_next, pc_inc, target;
    logic [NBITS_D-1:0]     ir, ir_next;
    logic [NBITS_D-1:0]     acc, acc_next;
    logic [NBITS_D-1:0]     imm, alu_b, alu_result;
    logic [2:0]             flags, flags_next;
    logic [OPCODE-1:0]      op_field;
    logic [NBITS_OPND-1:0]  operand;
    opcode_t                op;
    alu_op_t                alu_op;
    logic                   alu_carry;
    logic                   acc_we, c_we;
    logic                   is_store;

    // Instruction field split and sign-extended immediate.
    assign op_field = ir[NBITS_D-1 -: OPCODE];
    assign operand  = ir[NBITS_OPND-1:0];
    assign imm      = {{OPCODE{operand[NBITS_OPND-1]}}, operand};
    assign target   = operand[NBITS_O-1:0];
    assign pc_inc   = pc + NBITS_O'(1);

    // A wider opcode field with any bit above the 5-bit map set decodes as NOP.
    if (OPCODE > OP_W) begin : g_wide_op
        assign op = (op_field[OPCODE-1:OP_W] == '0) ? op_field[OP_W-1:0] : OP_NOP;
    end else begin : g_narrow_op
        assign op = OP_W'(op_field);
    end

    assign is_store = (op == OP_STO);
    assign alu_op   = alu_sel(op);
    // Memory-operand ops only reach the ALU in S_MEM, immediates in S_EXEC.
    assign alu_b    = (state == S_MEM) ? i_OutData : imm;

    bip_alu #(
        .NBITS_D (NBITS_D)
    ) u_alu (
        .op     (alu_op),
        .a      (acc),
        .b      (alu_b),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // Next-state, PC, IR, ACC and flag updates for the current FSM state.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        acc_next   = acc;
        flags_next = flags;
        acc_we     = 1'b0;
        c_we       = 1'b0;
        case (state)
            S_FETCH: begin
                if (i_PmAck) begin
                    ir_next    = i_Instruction;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_FETCH;
                pc_next    = pc_inc;
                if (op == OP_HLT) begin
                    state_next = S_HALT;
                    pc_next    = pc;
                end else if (is_mem_op(op)) begin
                    // PC advances only once the data transaction completes.
                    state_next = S_MEM;
                    pc_next    = pc;
                end else if (op == OP_LDI) begin
                    acc_next = imm;
                    acc_we   = 1'b1;
                end else if (is_alu_imm_op(op)) begin
                    acc_next = alu_result;
                    acc_we   = 1'b1;
                    c_we     = 1'b1;
                end else begin
                    case (op)
                        OP_BEQ:  if (acc == '0)        pc_next = target;
                        OP_BNE:  if (acc != '0)        pc_next = target;
                        OP_BLT:  if (acc[NBITS_D-1])   pc_next = target;
                        OP_JMP:                        pc_next = target;
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                if (i_DmAck) begin
                    state_next = S_FETCH;
                    pc_next    = pc_inc;
                    if (op == OP_LD) begin
                        acc_next = i_OutData;
                        acc_we   = 1'b1;
                    end else if (!is_store) begin
                        acc_next = alu_result;
                        acc_we   = 1'b1;
                        c_we     = 1'b1;
                    end
                end
            end
            S_HALT: ;
            default: state_next = S_FETCH;
        endcase
        if (acc_we) begin
            flags_next[FLAG_Z] = (acc_next == '0);
            flags_next[FLAG_N] = acc_next[NBITS_D-1];
        end
        if (c_we) begin
            flags_next[FLAG_C] = alu_carry;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample together.
        if (!i_reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Architectural registers: PC, IR, ACC and flags.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc    <= RESET_PC;
            ir    <= '0;
            acc   <= '0;
            flags <= '0;
        end else begin
            pc    <= pc_next;
            ir    <= ir_next;
            acc   <= acc_next;
            flags <= flags_next;
        end
    end

    // Requests are gated by reset so they drop the instant reset asserts.
    assign o_PmReq  = i_reset && (state == S_FETCH);
    assign o_Rd     = i_reset && (state == S_MEM) && !is_store;
    assign o_Wr     = i_reset && (state == S_MEM) && is_store;
    assign o_Halt   = (state == S_HALT);
    assign o_PmAddr = pc;
    assign o_DmAddr = operand[NBITS_O-1:0];
    assign o_InData = acc;
    assign o_Flags  = flags;

endmodule

// File: tb/tb_bip_cpu_hs.sv
// Directed self-checking bench for bip_cpu_hs: behavioural program/data
// memories with programmable wait states, and scoreboards of expected fetch
// addresses and expected data writes checked as the core issues them.
module tb_bip_cpu_hs;
    import bip_pkg::*;

    localparam int NO = 11;
    localparam int ND = 16;

    typedef struct packed {
        logic [NO-1:0] addr;
        logic [ND-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main core (RESET_PC = 0).
    logic          rst_n;
    logic [ND-1:0] instr, rdata;
    logic          pm_ack, dm_ack;
    logic [NO-1:0] pm_addr, dm_addr;
    logic          pm_req, rd, wr, halt;
    logic [ND-1:0] in_data;
    logic [2:0]    flags;

    // Second core for the PC wrap case (RESET_PC = 0x7FF).
    logic          rst2_n;
    logic [ND-1:0] instr2;
    logic          pm2_ack;
    logic [NO-1:0] pm_addr2, dm_addr2;
    logic          pm_req2, rd2, wr2, halt2;
    logic [ND-1:0] in_data2;
    logic [2:0]    flags2;

    bip_cpu_hs #(.NBITS_O(NO), .NBITS_D(ND), .OPCODE(5), .RESET_PC(11'h000)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_Instruction(instr), .i_PmAck(pm_ack),
        .i_OutData(rdata), .i_DmAck(dm_ack), .o_PmAddr(pm_addr), .o_PmReq(pm_req),
        .o_DmAddr(dm_addr), .o_Rd(rd), .o_Wr(wr), .o_InData(in_data),
        .o_Flags(flags), .o_Halt(halt)
    );

    bip_cpu_hs #(.NBITS_O(NO), .NBITS_D(ND), .OPCODE(5), .RESET_PC(11'h7FF)) dut2 (
        .i_clk(clk), .i_reset(rst2_n), .i_Instruction(instr2), .i_PmAck(pm2_ack),
        .i_OutData(16'h0000), .i_DmAck(1'b0), .o_PmAddr(pm_addr2), .o_PmReq(pm_req2),
        .o_DmAddr(dm_addr2), .o_Rd(rd2), .o_Wr(wr2), .o_InData(in_data2),
        .o_Flags(flags2), .o_Halt(halt2)
    );

    logic [ND-1:0] pmem [0:(1<<NO)-1];
    logic [ND-1:0] dmem [0:(1<<NO)-1];
    logic [NO-1:0] exp_fetch [$];
    wr_t           exp_wr [$];

    int checks   = 0;
    int failures = 0;
    int pm_wait  = 0;
    int dm_wait  = 0;
    int pm_cnt   = 0;
    int dm_cnt   = 0;

    function automatic logic [ND-1:0] enc(input opcode_t op, input logic [10:0] opnd);
        return {op, opnd};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < (1 << NO); i++) begin
            pmem[i] = enc(OP_NOP, 11'h000);
            dmem[i] = '0;
        end
    endtask

    // Memory responder, evaluated at the falling edge from the live requests.
    task automatic respond();
        logic [NO-1:0] ef;
        wr_t           ew;
        pm_ack = 1'b0;
        instr  = '0;
        dm_ack = 1'b0;
        rdata  = '0;
        if (pm_req) begin
            if (pm_cnt >= pm_wait) begin
                pm_ack = 1'b1;
                instr  = pmem[pm_addr];
                pm_cnt = 0;
                if (exp_fetch.size() == 0) begin
                    check("fetch_unexpected", {21'b0, pm_addr}, 32'hFFFF_FFFF);
                end else begin
                    ef = exp_fetch.pop_front();
                    check("fetch_addr", {21'b0, pm_addr}, {21'b0, ef});
                end
            end else begin
                pm_cnt++;
            end
        end else begin
            pm_cnt = 0;
        end
        if (rd || wr) begin
            if (dm_cnt >= dm_wait) begin
                dm_ack = 1'b1;
                dm_cnt = 0;
                if (wr) begin
                    dmem[dm_addr] = in_data;
                    if (exp_wr.size() == 0) begin
                        check("write_unexpected", {5'b0, dm_addr, in_data}, 32'hFFFF_FFFF);
                    end else begin
                        ew = exp_wr.pop_front();
                        check("write_addr", {21'b0, dm_addr}, {21'b0, ew.addr});
                        check("write_data", {16'b0, in_data}, {16'b0, ew.data});
                    end
                end else begin
                    rdata = dmem[dm_addr];
                end
            end else begin
                dm_cnt++;
            end
        end else begin
            dm_cnt = 0;
        end
    endtask

    // One clock: respond at the falling edge, then sample 1 ns after the rising edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            respond();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        pm_ack = 1'b0;
        dm_ack = 1'b0;
        instr  = '0;
        rdata  = '0;
        pm_cnt = 0;
        dm_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pmreq", {31'b0, pm_req}, 32'd0);
        check("rst_rd",    {31'b0, rd},     32'd0);
        check("rst_wr",    {31'b0, wr},     32'd0);
        check("rst_halt",  {31'b0, halt},   32'd0);
        check("rst_flags", {29'b0, flags},  32'd0);
        check("rst_pc",    {21'b0, pm_addr}, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n = 0;
        while (!halt && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, {31'b0, halt}, 32'd1);
    endtask

    task automatic drained(input string tag);
        check({tag, "_fetch_left"}, exp_fetch.size(), 32'd0);
        check({tag, "_write_left"}, exp_wr.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rd_cycles;
        rst_n   = 1'b0;
        rst2_n  = 1'b0;
        pm2_ack = 1'b1;
        instr2  = enc(OP_NOP, 11'h000);
        pm_ack  = 1'b0;
        dm_ack  = 1'b0;
        instr   = '0;
        rdata   = '0;

        // ---- Test 1: LDI 5; ADDI 3; STO 0x010; HLT, zero wait ----
        clear_mem();
        pmem[0] = enc(OP_LDI, 11'd5);
        pmem[1] = enc(OP_ADDI, 11'd3);
        pmem[2] = enc(OP_STO, 11'h010);
        pmem[3] = enc(OP_HLT, 11'h000);
        pm_wait = 0; dm_wait = 0;
        exp_fetch = '{11'h000, 11'h001, 11'h002, 11'h003};
        exp_wr.push_back('{addr: 11'h010, data: 16'h0008});
        do_reset();
        tick(8);
        check("t1_not_halted_e8", {31'b0, halt}, 32'd0);
        tick(1);
        check("t1_halt_e9", {31'b0, halt}, 32'd1);
        check("t1_flags", {29'b0, flags}, 32'd0);
        tick(5);
        check("t1_pc_frozen", {21'b0, pm_addr}, 32'h003);
        check("t1_no_pmreq", {31'b0, pm_req}, 32'd0);
        check("t1_no_rd", {31'b0, rd}, 32'd0);
        check("t1_no_wr", {31'b0, wr}, 32'd0);
        drained("t1");

        // ---- Test 2: LD 0x020 with three wait states ----
        clear_mem();
        pmem[0] = enc(OP_LD, 11'h020);
        pmem[1] = enc(OP_STO, 11'h021);
        pmem[2] = enc(OP_HLT, 11'h000);
        dmem[11'h020] = 16'h8001;
        pm_wait = 0; dm_wait = 3;
        exp_fetch = '{11'h000, 11'h001, 11'h002};
        exp_wr.push_back('{addr: 11'h021, data: 16'h8001});
        do_reset();
        tick(2);
        rd_cycles = 0;
        while (rd && rd_cycles < 10) begin
            rd_cycles++;
            check("t2_dm_addr_stable", {21'b0, dm_addr}, 32'h020);
            check("t2_flags_before_ack", {29'b0, flags}, 32'd0);
            tick(1);
        end
        check("t2_rd_cycles", rd_cycles, 32'd4);
        check("t2_flags_after_ld", {29'b0, flags}, 32'b010);
        wait_halt("t2_halt", 40);
        drained("t2");

        // ---- Test 3: BEQ taken / not taken, BLT not taken, BNE taken ----
        clear_mem();
        pmem[0]      = enc(OP_LDI, 11'd0);
        pmem[1]      = enc(OP_BEQ, 11'h040);
        pmem[11'h40] = enc(OP_LDI, 11'd1);
        pmem[11'h41] = enc(OP_BEQ, 11'h060);
        pmem[11'h42] = enc(OP_BLT, 11'h050);
        pmem[11'h43] = enc(OP_BNE, 11'h070);
        pmem[11'h70] = enc(OP_STO, 11'h030);
        pmem[11'h71] = enc(OP_HLT, 11'h000);
        pm_wait = 0; dm_wait = 0;
        exp_fetch = '{11'h000, 11'h001, 11'h040, 11'h041, 11'h042, 11'h043, 11'h070, 11'h071};
        exp_wr.push_back('{addr: 11'h030, data: 16'h0001});
        do_reset();
        tick(2);
        check("t3_flags_zero", {29'b0, flags}, 32'b100);
        tick(2);
        check("t3_beq_taken", {21'b0, pm_addr}, 32'h040);
        tick(4);
        check("t3_beq_not_taken", {21'b0, pm_addr}, 32'h042);
        wait_halt("t3_halt", 40);
        drained("t3");

        // ---- Test 4: SUBI borrow, SRL carry, ADD mem carry, ANDI clears C ----
        clear_mem();
        pmem[0]  = enc(OP_LDI,  11'd0);
        pmem[1]  = enc(OP_SUBI, 11'd1);
        pmem[2]  = enc(OP_STO,  11'h050);
        pmem[3]  = enc(OP_SRL,  11'd4);
        pmem[4]  = enc(OP_STO,  11'h051);
        pmem[5]  = enc(OP_ADD,  11'h050);
        pmem[6]  = enc(OP_STO,  11'h052);
        pmem[7]  = enc(OP_ANDI, 11'd0);
        pmem[8]  = enc(OP_STO,  11'h053);
        pmem[9]  = enc(OP_HLT,  11'h000);
        pm_wait = 0; dm_wait = 0;
        for (int i = 0; i < 10; i++) exp_fetch.push_back(NO'(i));
        exp_wr.push_back('{addr: 11'h050, data: 16'hFFFF});
        exp_wr.push_back('{addr: 11'h051, data: 16'h0FFF});
        exp_wr.push_back('{addr: 11'h052, data: 16'h0FFE});
        exp_wr.push_back('{addr: 11'h053, data: 16'h0000});
        do_reset();
        tick(4);
        check("t4_subi_flags", {29'b0, flags}, 32'b011);
        tick(5);
        check("t4_srl_flags", {29'b0, flags}, 32'b001);
        tick(6);
        check("t4_add_mem_flags", {29'b0, flags}, 32'b001);
        tick(5);
        check("t4_andi_flags", {29'b0, flags}, 32'b100);
        wait_halt("t4_halt", 40);
        drained("t4");

        // ---- Test 5: reset during a withheld write ----
        clear_mem();
        pmem[0] = enc(OP_LDI, 11'd7);
        pmem[1] = enc(OP_STO, 11'h070);
        pm_wait = 0; dm_wait = 1000;
        exp_fetch = '{11'h000, 11'h001};
        do_reset();
        tick(4);
        check("t5_wr_pending", {31'b0, wr}, 32'd1);
        check("t5_wr_addr", {21'b0, dm_addr}, 32'h070);
        check("t5_wr_data", {16'b0, in_data}, 32'h0007);
        tick(2);
        check("t5_wr_held", {31'b0, wr}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_wr_drop", {31'b0, wr}, 32'd0);
        check("t5_pmreq_drop", {31'b0, pm_req}, 32'd0);
        check("t5_rd_drop", {31'b0, rd}, 32'd0);
        check("t5_write_discarded", {16'b0, dmem[11'h070]}, 32'h0000);
        clear_mem();
        pmem[0] = enc(OP_STO, 11'h071);
        pmem[1] = enc(OP_HLT, 11'h000);
        dm_wait = 0;
        exp_fetch = '{11'h000, 11'h001};
        exp_wr.push_back('{addr: 11'h071, data: 16'h0000});
        do_reset();
        wait_halt("t5_halt", 40);
        drained("t5");

        // ---- Test 6: RESET_PC = 0x7FF, NOP wraps the PC to 0 ----
        check("t6_rst_pc", {21'b0, pm_addr2}, 32'h7FF);
        check("t6_rst_pmreq", {31'b0, pm_req2}, 32'd0);
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_exec_no_req", {31'b0, pm_req2}, 32'd0);
        check("t6_exec_pc", {21'b0, pm_addr2}, 32'h7FF);
        @(posedge clk);
        #1;
        check("t6_wrap_pc", {21'b0, pm_addr2}, 32'h000);
        check("t6_wrap_req", {31'b0, pm_req2}, 32'd1);
        check("t6_side_outputs", {5'b0, rd2, wr2, halt2, flags2, dm_addr2, in_data2}, 32'd0);
        rst2_n = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bip_cpu_hs.md
Name: bip_cpu_hs

Overview:
- Parametrised accumulator CPU, the next generation of the team's BIP core.
- Adds a fetch/execute/memory state machine with req/ack handshakes to program and data memory, so both memories may insert wait states.
- Adds immediate and logical/shift instructions, conditional branches, and Z/N/C status flags.
- Sits between program memory and data memory at the same level as the current cpu top.

Parameters:
- NBITS_O, 11, program and data address width.
- NBITS_D, 16, data, accumulator and instruction width.
- OPCODE, 5, opcode field width (instruction MSBs).
- RESET_PC, 0, PC value loaded at reset.
- Legality: NBITS_O <= NBITS_D-OPCODE. Operand field = NBITS_D-OPCODE bits.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_Instruction  in  NBITS_D  program memory read data, valid when i_PmAck=1.
- i_PmAck  in  1  program memory acknowledge.
- i_OutData  in  NBITS_D  data memory read data, valid when i_DmAck=1.
- i_DmAck  in  1  data memory acknowledge (read or write).
- o_PmAddr  out  NBITS_O  fetch address (= PC).
- o_PmReq  out  1  fetch request.
- o_DmAddr  out  NBITS_O  data address (low NBITS_O bits of operand).
- o_Rd  out  1  data read request.
- o_Wr  out  1  data write request.
- o_InData  out  NBITS_D  write data (= ACC).
- o_Flags  out  3  {Z,N,C}.
- o_Halt  out  1  core halted.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - PC=RESET_PC, ACC=0, IR=0, flags=0, state=S_FETCH.
  - o_PmReq=0, o_Rd=0, o_Wr=0, o_Halt=0.
  - o_PmReq rises on the first edge after release.
- States:
  - S_FETCH: o_PmReq=1, o_PmAddr=PC. On the edge with i_PmAck=1, latch IR and go to S_EXEC.
  - S_EXEC: decode IR. ALU/immediate/branch/NOP ops complete here and go to S_FETCH. LD/STO/ADD/SUB/AND/OR/XOR (memory operand) go to S_MEM. HLT goes to S_HALT.
  - S_MEM: o_Rd=1 (loads and ALU-mem ops) or o_Wr=1 (STO). o_DmAddr and o_InData held stable until i_DmAck. On the ack edge: update ACC/flags, PC+1, go to S_FETCH.
  - S_HALT: o_Halt=1, no requests, PC frozen. Exit only by reset.
- Requests are level signals: asserted until acked, never withdrawn early except by reset. Ack with no request is ignored.
- Latency at zero wait (ack in the same cycle as req): 2 cycles for non-memory instructions, 3 for memory instructions.
- Opcodes (hex, 5-bit):
  - 00 HLT, 01 STO, 02 LD, 03 LDI.
  - 04 ADD, 05 ADDI, 06 SUB, 07 SUBI.
  - 08 AND, 09 ANDI, 0A OR, 0B ORI, 0C XOR, 0D XORI.
  - 0E SLL, 0F SRL, 10 SRA.
  - 11 BEQ, 12 BNE, 13 BLT, 14 JMP.
  - All others: NOP (PC+1).
- Immediates: operand field sign-extended to NBITS_D. Shifts use operand[$clog2(NBITS_D)-1:0]. Shift amount 0 leaves ACC unchanged.
- Arithmetic: NBITS_D-bit, wraps modulo 2^NBITS_D.
  - C = carry-out for ADD; C = borrow for SUB.
  - C cleared by logical ops; C = last bit shifted out for shifts.
- Flags:
  - Z and N are updated on every ACC write.
  - C is updated only by arithmetic, logical and shift ops.
  - STO, branches and NOP leave all flags unchanged.
- Branches: BEQ if ACC==0, BNE if ACC!=0, BLT if ACC[MSB]=1, JMP always.
  - Taken: PC = operand[NBITS_O-1:0]. Not taken: PC+1.
- PC increment wraps from 2^NBITS_O-1 to 0.
- Reset mid-operation (any state): requests drop immediately (combinational on reset), and all registers take their reset values. The bench must accept an unfinished write as discarded.

Decomposition:
- Package bip_pkg: opcode localparams, state encoding (S_FETCH, S_EXEC, S_MEM, S_HALT), flag bit indices.
- Sub-module bip_alu: combinational; inputs op, a, b; outputs result, carry.
- The FSM, PC, IR and ACC stay in bip_cpu_hs.

Test Plan:
- Program LDI 5; ADDI 3; STO 0x010; HLT with zero-wait acks -> one write at 0x010 with data 0x0008; o_Halt=1 after the 9th edge post-reset; o_PmAddr stays 0x003; no further requests.
- LD 0x020 with i_DmAck delayed 3 cycles, memory holding 0x8001 -> o_Rd high for 4 cycles with o_DmAddr=0x020 stable; ACC=0x8001 only after ack; Z=0, N=1.
- LDI 0; BEQ 0x040 -> next fetch at 0x040. Then LDI 1; BEQ 0x060 -> fetch at 0x042.
- LDI 0; SUBI 1 -> ACC=0xFFFF, C=1, N=1, Z=0. Then SRL 4 -> ACC=0x0FFF, C=1, N=0.
- Assert reset while in S_MEM with o_Wr=1 and ack withheld -> o_Wr drops in the same cycle; after release, fetch at RESET_PC with ACC=0.
- RESET_PC=0x7FF, instruction NOP -> next fetch address 0x000.
